// File: rtl/alu_exerciser.sv
// Sequential initiator for the 2-bit ALU: single commands over valid/ready, or an
// exhaustive 128-vector sweep folded into a 16-bit signature. States: IDLE | SETTLE | CAPTURE | RESP.
module alu_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_a,
  input  logic [1:0]  cmd_b,
  input  logic        cmd_cin,
  input  logic [1:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_result,
  output logic [6:0]  rsp_vector,
  input  logic        sweep_start,
  output logic        sweep_busy,
  output logic        sweep_done,
  output logic [15:0] sweep_signature,
  output logic        alu_a0,
  output logic        alu_a1,
  output logic        alu_b0,
  output logic        alu_b1,
  output logic        alu_cin,
  output logic        alu_s0,
  output logic        alu_s1,
  input  logic        alu_out0,
  input  logic        alu_out1,
  input  logic        alu_out2,
  input  logic        alu_out3
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_vec;
  logic [6:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_result;
  logic [15:0] r_sig;
  logic        r_sweep;
  logic        r_done;
  logic [3:0]  w_alu_out;
  logic        w_start;
  logic        w_accept;
  logic        w_capture;
  logic        w_sweep_step;
  logic        w_sweep_end;

  assign w_alu_out = {alu_out3, alu_out2, alu_out1, alu_out0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_sweep_step = 1'b0;
    w_sweep_end  = 1'b0;
    case (r_state)
      IDLE: begin
        // sweep_start wins; a simultaneous command simply stays pending
        if (sweep_start) begin
          w_start     = 1'b1;
          w_state_nxt = SETTLE;
        end else if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == 4'd0) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        w_capture = 1'b1;
        if (!r_sweep) begin
          w_state_nxt = RESP;
        end else if (r_idx == 7'd127) begin
          w_sweep_end = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_sweep_step = 1'b1;
          w_state_nxt  = SETTLE;
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_sig    <= '0;
      r_sweep  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_sweep_end;
      if (w_start || w_accept || w_sweep_step) r_cnt <= SETTLE_INIT;
      else if (r_state == SETTLE && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_start) begin
        r_vec   <= '0;
        r_idx   <= '0;
        r_sig   <= '0;
        r_sweep <= 1'b1;
      end else if (w_accept) begin
        r_vec <= {cmd_sel, cmd_cin, cmd_b, cmd_a};
      end else if (w_sweep_step) begin
        r_vec <= r_idx + 7'd1;
        r_idx <= r_idx + 7'd1;
      end
      if (w_capture) r_result <= w_alu_out;
      if (w_capture && r_sweep) r_sig <= {r_sig[14:0], r_sig[15]} ^ {12'h000, w_alu_out};
      if (w_sweep_end) r_sweep <= 1'b0;
    end
  end

  assign cmd_ready       = (r_state == IDLE) && !sweep_start;
  assign rsp_valid       = (r_state == RESP);
  assign rsp_result      = r_result;
  assign rsp_vector      = r_vec;
  assign sweep_busy      = r_sweep;
  assign sweep_done      = r_done;
  assign sweep_signature = r_sig;

  assign alu_a0  = r_vec[0];
  assign alu_a1  = r_vec[1];
  assign alu_b0  = r_vec[2];
  assign alu_b1  = r_vec[3];
  assign alu_cin = r_vec[4];
  assign alu_s0  = r_vec[5];
  assign alu_s1  = r_vec[6];

endmodule

// File: tb/tb_alu_exerciser.sv
// Directed bench for alu_exerciser: default build plus a SETTLE_CYCLES=1 build,
// each driven by a behavioural ALU stub whose behaviour is chosen by stub_mode.
module tb_alu_exerciser;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_vec = 0;
  int          n_err = 0;
  int          stub_mode = 0;

  logic        cmd_valid, cmd_ready, cmd_cin, rsp_valid, rsp_ready;
  logic [1:0]  cmd_a, cmd_b, cmd_sel;
  logic [3:0]  rsp_result;
  logic [6:0]  rsp_vector;
  logic        sweep_start, sweep_busy, sweep_done;
  logic [15:0] sweep_signature;
  logic        alu_a0, alu_a1, alu_b0, alu_b1, alu_cin, alu_s0, alu_s1;
  logic [3:0]  alu_out;
  logic [6:0]  drv;

  logic        d1_cmd_valid, d1_cmd_ready, d1_cmd_cin, d1_rsp_valid, d1_rsp_ready;
  logic [1:0]  d1_cmd_a, d1_cmd_b, d1_cmd_sel;
  logic [3:0]  d1_rsp_result;
  logic [6:0]  d1_rsp_vector;
  logic        d1_sweep_start, d1_sweep_busy, d1_sweep_done;
  logic [15:0] d1_sweep_signature;
  logic        d1_a0, d1_a1, d1_b0, d1_b1, d1_cin, d1_s0, d1_s1;
  logic [3:0]  d1_alu_out;
  logic [6:0]  d1_drv;

  always #5 clk = ~clk;

  // mode 0: simple ALU (sel 00 = a+b+cin), 1: constant 1, 2: echoes a0
  function automatic logic [3:0] stub(input int m, input logic [6:0] v);
    if (m == 1) return 4'h1;
    if (m == 2) return {3'b000, v[0]};
    case (v[6:5])
      2'b00:   return {2'b00, v[1:0]} + {2'b00, v[3:2]} + {3'b000, v[4]};
      2'b01:   return {2'b00, v[1:0] & v[3:2]};
      2'b10:   return {2'b00, v[1:0] | v[3:2]};
      default: return {2'b00, v[1:0] ^ v[3:2]};
    endcase
  endfunction

  assign drv        = {alu_s1, alu_s0, alu_cin, alu_b1, alu_b0, alu_a1, alu_a0};
  assign alu_out    = stub(stub_mode, drv);
  assign d1_drv     = {d1_s1, d1_s0, d1_cin, d1_b1, d1_b0, d1_a1, d1_a0};
  assign d1_alu_out = stub(stub_mode, d1_drv);

  alu_exerciser u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_cin(cmd_cin), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_vector(rsp_vector),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .sweep_signature(sweep_signature),
    .alu_a0(alu_a0), .alu_a1(alu_a1), .alu_b0(alu_b0), .alu_b1(alu_b1),
    .alu_cin(alu_cin), .alu_s0(alu_s0), .alu_s1(alu_s1),
    .alu_out0(alu_out[0]), .alu_out1(alu_out[1]), .alu_out2(alu_out[2]), .alu_out3(alu_out[3])
  );

  alu_exerciser #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_a(d1_cmd_a), .cmd_b(d1_cmd_b),
    .cmd_cin(d1_cmd_cin), .cmd_sel(d1_cmd_sel),
    .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_result(d1_rsp_result),
    .rsp_vector(d1_rsp_vector),
    .sweep_start(d1_sweep_start), .sweep_busy(d1_sweep_busy), .sweep_done(d1_sweep_done),
    .sweep_signature(d1_sweep_signature),
    .alu_a0(d1_a0), .alu_a1(d1_a1), .alu_b0(d1_b0), .alu_b1(d1_b1),
    .alu_cin(d1_cin), .alu_s0(d1_s0), .alu_s1(d1_s1),
    .alu_out0(d1_alu_out[0]), .alu_out1(d1_alu_out[1]), .alu_out2(d1_alu_out[2]),
    .alu_out3(d1_alu_out[3])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] a, input logic [1:0] b, input logic cin,
                        input logic [1:0] sel, input logic [3:0] exp_res,
                        input logic [6:0] exp_vec, input string tag);
    int lat;
    cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_sel = sel;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, " drives"}, drv, exp_vec);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " result"}, rsp_result, exp_res);
    chk({tag, " vector"}, rsp_vector, exp_vec);
    tick();
    chk({tag, " idle after rsp"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int done_cnt;
    int vld_cnt;
    int lat;
    logic [15:0] msig;

    rst_n = 1'b0;
    cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_cin = 0; cmd_sel = 0;
    rsp_ready = 0; sweep_start = 0;
    d1_cmd_valid = 0; d1_cmd_a = 0; d1_cmd_b = 0; d1_cmd_cin = 0; d1_cmd_sel = 0;
    d1_rsp_ready = 0; d1_sweep_start = 0;
    #3;
    chk("reset rsp", {rsp_valid, rsp_result, rsp_vector}, 0);
    chk("reset drives/sweep", {drv, sweep_busy, sweep_done, sweep_signature}, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    sweep_start = 1'b1;
    #1;
    chk("reset cmd_ready with start", cmd_ready, 0);
    sweep_start = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    do_cmd(2'd3, 2'd2, 1'b1, 2'b00, 4'b0110, 7'b0011011, "add3+2+1");
    do_cmd(2'd2, 2'd3, 1'b0, 2'b11, 4'b0001, 7'b1101110, "xor2^3");

    // backpressure: a=1 b=1 cin=0 sel=00 -> 2, vector 0000101
    cmd_a = 2'd1; cmd_b = 2'd1; cmd_cin = 1'b0; cmd_sel = 2'b00;
    rsp_ready = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("bp first rsp", {rsp_valid, cmd_ready, rsp_result, rsp_vector}, {1'b1, 1'b0, 4'h2, 7'h05});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp hold", {rsp_valid, cmd_ready, rsp_result, rsp_vector}, {1'b1, 1'b0, 4'h2, 7'h05});
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp release", {rsp_valid, cmd_ready}, 2'b01);
    chk("bp drives kept", drv, 7'h05);

    // reset during SETTLE of a command
    cmd_a = 2'd3; cmd_b = 2'd3; cmd_cin = 1'b1; cmd_sel = 2'b00;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("settle reset rsp", {rsp_valid, rsp_result, rsp_vector}, 0);
    chk("settle reset drives/sweep", {drv, sweep_busy, sweep_done, sweep_signature}, 0);
    chk("settle reset cmd_ready", cmd_ready, 1);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      tick();
      if (rsp_valid) cnt++;
    end
    chk("settle reset no rsp", cnt, 0);

    // sweep vs pending command, constant-1 stub, mid-sweep start ignored
    stub_mode = 1;
    cmd_a = 2'd1; cmd_b = 2'd2; cmd_cin = 1'b0; cmd_sel = 2'b00;
    cmd_valid = 1'b1; sweep_start = 1'b1;
    #1;
    chk("priority cmd_ready", cmd_ready, 0);
    tick();
    sweep_start = 1'b0;
    done_cnt = 0; vld_cnt = 0;
    for (int k = 0; k < 384; k++) begin
      chk("sweep busy", sweep_busy, 1);
      chk("sweep drives", drv, k / 3);
      if (k % 64 == 0) chk("sweep cmd blocked", cmd_ready, 0);
      done_cnt += int'(sweep_done);
      vld_cnt += int'(rsp_valid);
      if (k == 100) sweep_start = 1'b1;
      if (k == 101) sweep_start = 1'b0;
      tick();
    end
    chk("sweep end flags", {sweep_busy, sweep_done}, 2'b01);
    chk("sweep const1 signature", sweep_signature, 16'h0000);
    chk("sweep early done/rsp", {done_cnt, vld_cnt}, 0);
    stub_mode = 0;
    tick();
    cmd_valid = 1'b0;
    chk("pending cmd accepted", drv, 7'b0001001);
    chk("sweep done single pulse", sweep_done, 0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("pending cmd latency", lat, 3);
    chk("pending cmd result", rsp_result, 4'h3);
    tick();

    // sweep with a0-echo stub against the bench signature model
    stub_mode = 2;
    msig = 16'h0000;
    for (int v = 0; v < 128; v++) msig = {msig[14:0], msig[15]} ^ {15'b0, v[0]};
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    cnt = 0;
    while (!sweep_done && cnt < 600) begin
      tick();
      cnt++;
    end
    chk("a0 sweep length", cnt, 384);
    chk("a0 sweep signature", sweep_signature, msig);
    tick();

    // reset at sweep vector 60
    stub_mode = 1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (180) tick();
    chk("vec60 drives", drv, 60);
    rst_n = 1'b0;
    #1;
    chk("vec60 reset", {sweep_busy, sweep_done, sweep_signature, drv}, 0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    repeat (400) begin
      tick();
      cnt += int'(sweep_done);
    end
    chk("vec60 no done", {cnt, 31'(sweep_busy)}, 0);

    // SETTLE_CYCLES=1 build: a=2 b=1 cin=1 -> 4, vector 0010110
    stub_mode = 0;
    d1_cmd_a = 2'd2; d1_cmd_b = 2'd1; d1_cmd_cin = 1'b1; d1_cmd_sel = 2'b00;
    d1_rsp_ready = 1'b1; d1_cmd_valid = 1'b1;
    tick();
    d1_cmd_valid = 1'b0;
    lat = 0;
    while (!d1_rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("s1 latency", lat, 2);
    chk("s1 result/vector", {d1_rsp_result, d1_rsp_vector}, {4'h4, 7'b0010110});
    tick();
    stub_mode = 1;
    d1_sweep_start = 1'b1;
    tick();
    d1_sweep_start = 1'b0;
    cnt = 0;
    while (d1_sweep_busy && cnt < 600) begin
      cnt++;
      tick();
    end
    chk("s1 sweep length", cnt, 256);
    chk("s1 sweep done/sig", {d1_sweep_done, d1_sweep_signature}, {1'b1, 16'h0000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
